result_mem_writer: RTL
======================

# result_mem_writer

Parametrised multi-channel writer that takes dot-product results from the datapath over a valid/ready handshake and stores them in the result memory's write port. Each accepted beat carries NUM_CH results, written to consecutive addresses. Results are saturated to the memory width, addressing runs from a base address with configurable wrap, and the block signals completion after a programmed number of beats. It sits between the dot-product engine and the result memory.

## Interface
- DATA_WIDTH, 16, memory word width
- ADDR_WIDTH, 6, memory address width
- RESULT_WIDTH, 32, width of one signed result
- NUM_CH, 2, results per input beat (≥1)
- BASE_ADDR, 0, first write address after start
- WRAP_EN, 1, 1 = address wraps modulo 2^ADDR_WIDTH; 0 = stop writing at top address
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse that begins a job; ignored while busy
- num_beats  in  ADDR_WIDTH+1  beats in the job, sampled on start
- res_valid  in  1  result beat valid
- res_data  in  NUM_CH*RESULT_WIDTH  channel c at bits [c*RESULT_WIDTH +: RESULT_WIDTH]
- res_ready  out  1  beat accepted on res_valid & res_ready
- write_en  out  1  memory write strobe
- write_address  out  ADDR_WIDTH  memory address
- data_in  out  DATA_WIDTH  memory write data
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- sat_flag  out  1  sticky: a result was saturated during the job
- overflow  out  1  sticky: a write was dropped (WRAP_EN=0 only)

## Operation
- FSM states: IDLE, CAPTURE, WRITE, DONE.
- IDLE: when start is high, latch num_beats, set the address pointer to BASE_ADDR, clear sat_flag and overflow, and set busy. If num_beats=0, go to DONE; otherwise go to CAPTURE.
- CAPTURE: res_ready=1. On handshake, latch all NUM_CH results, clear the channel index, and go to WRITE.
- WRITE: lasts exactly NUM_CH cycles, processing channel 0 first.
  - Each cycle writes the current channel to the pointer address, then increments the pointer.
  - After the last channel, decrement the remaining-beat count. Go to DONE if it reaches 0; otherwise go to CAPTURE.
- DONE: done=1 for one cycle, busy is cleared, then go to IDLE.
- Conversion is signed.
  - If RESULT_WIDTH ≤ DATA_WIDTH: sign-extend.
  - Otherwise: values above 2^(DATA_WIDTH-1)-1 clamp to that value, values below -2^(DATA_WIDTH-1) clamp to that value, and sat_flag is set.
- Address rules:
  - WRAP_EN=1: the pointer wraps from 2^ADDR_WIDTH-1 to 0.
  - WRAP_EN=0: after address 2^ADDR_WIDTH-1 has been written, all further writes in the job are suppressed (write_en stays 0) and overflow is set. The handshake and beat counting continue, so done still fires.
- start during busy has no effect. res_valid outside CAPTURE is not accepted.
- sat_flag and overflow hold their values through IDLE until the next start.

## Timing
- Reset (rst_n=0 at an edge): the FSM goes to IDLE, and all outputs, the pointer and the counters are 0. This applies mid-job too: the job is abandoned with no done pulse.
- All outputs are registered.
- Beat accepted at edge k: write_en is high for cycles k+1 … k+NUM_CH, one channel per cycle, with write_address and data_in valid in the same cycles.
- res_ready is high in the cycle after the last write of the previous beat. Peak throughput is one beat per NUM_CH+1 cycles.
- done is high in the cycle after the final write; busy is low from the following cycle.
- start with num_beats=0: done is high in the cycle after start, with no writes.
- write_en is never high outside WRITE.

## Test plan
- Defaults, start with num_beats=3, beats {1,2},{3,4},{5,6} sent back-to-back:
  - required: writes (0,1),(1,2),(2,3),(3,4),(4,5),(5,6) as (address,data);
  - required: res_ready low during each 2-cycle write window;
  - required: a single done pulse after address 5.
- Saturation, beat {32'h0001_0000, 32'hFFFF_0000}:
  - required: data_in 16'h7FFF then 16'h8000;
  - required: sat_flag=1 until the next start, which clears it.
- Wrap:
  - WRAP_EN=1, BASE_ADDR=62, 2 beats: required addresses 62,63,0,1.
  - WRAP_EN=0, same stimulus: required writes at 62,63 only, then overflow=1, and done still pulses.
- Edge cases:
  - num_beats=0: required done one cycle after start, no write_en.
  - start pulsed mid-job: required no change to address or count.
  - res_valid held low for 5 cycles: required no writes and busy held.
- Reset during WRITE (after the first channel): required all outputs 0 on the next cycle and no done pulse. A new start then writes from BASE_ADDR.

Source files
------------

// File: rtl/result_mem_writer_if.sv
// Result beat handshake (datapath -> writer) and result memory write port (writer -> memory).
interface result_mem_writer_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 6,
  parameter int RESULT_WIDTH = 32,
  parameter int NUM_CH       = 2
);
  logic                           res_valid;
  logic                           res_ready;
  logic [NUM_CH*RESULT_WIDTH-1:0] res_data;
  logic                           write_en;
  logic [ADDR_WIDTH-1:0]          write_address;
  logic [DATA_WIDTH-1:0]          data_in;

  modport master (
    output res_valid, res_data,
    input  res_ready, write_en, write_address, data_in
  );

  modport slave (
    input  res_valid, res_data,
    output res_ready, write_en, write_address, data_in
  );
endinterface

// File: rtl/result_mem_writer.sv
// Stores NUM_CH saturated results per accepted beat at consecutive memory addresses.
// One beat per NUM_CH+1 cycles; res_ready only in CAPTURE; every output is a flop.
module result_mem_writer #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 6,
  parameter int RESULT_WIDTH = 32,
  parameter int NUM_CH       = 2,
  parameter int BASE_ADDR    = 0,
  parameter int WRAP_EN      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_flag,
  output logic                  overflow,
  result_mem_writer_if.slave    bus
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, DONE} state_t;

  state_t                         state, state_nxt;
  logic [NUM_CH*RESULT_WIDTH-1:0] beat_q, src;
  logic [CW-1:0]                  ch_q, ch_nxt, issue_ch;
  logic [ADDR_WIDTH-1:0]          ptr_q, ptr_nxt;
  logic [ADDR_WIDTH:0]            rem_q, rem_nxt;
  logic                           full_q, full_nxt;
  logic                           issue, drop, load_beat, clear_flags;
  logic [RESULT_WIDTH-1:0]        sel;
  logic [DATA_WIDTH-1:0]          conv;
  logic                           conv_sat;

  logic                           ready_q, we_q;
  logic [ADDR_WIDTH-1:0]          addr_q;
  logic [DATA_WIDTH-1:0]          data_q;

  always_comb begin
    state_nxt   = state;
    ch_nxt      = ch_q;
    ptr_nxt     = ptr_q;
    rem_nxt     = rem_q;
    full_nxt    = full_q;
    issue       = 1'b0;
    issue_ch    = ch_q;
    src         = beat_q;
    load_beat   = 1'b0;
    clear_flags = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          rem_nxt     = num_beats;
          ptr_nxt     = ADDR_WIDTH'(BASE_ADDR);
          full_nxt    = 1'b0;
          clear_flags = 1'b1;
          state_nxt   = (num_beats == '0) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        // Channel 0 is converted straight from the bus so its write lands the very next cycle.
        if (bus.res_valid) begin
          load_beat = 1'b1;
          issue     = 1'b1;
          issue_ch  = '0;
          ch_nxt    = '0;
          src       = bus.res_data;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (ch_q == LAST_CH) begin
          rem_nxt   = rem_q - 1'b1;
          state_nxt = (rem_q == (ADDR_WIDTH+1)'(1)) ? DONE : CAPTURE;
        end else begin
          issue    = 1'b1;
          issue_ch = ch_q + 1'b1;
          ch_nxt   = ch_q + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (issue) begin
      ptr_nxt = ptr_q + 1'b1;
      if (WRAP_EN == 0 && ptr_q == '1) full_nxt = 1'b1;
    end
  end

  assign drop = (WRAP_EN == 0) && full_q;
  assign sel  = src[int'(issue_ch)*RESULT_WIDTH +: RESULT_WIDTH];

  generate
    if (RESULT_WIDTH > DATA_WIDTH) begin : g_sat
      localparam logic [RESULT_WIDTH-1:0] MAX_V =
        {{(RESULT_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
      localparam logic [RESULT_WIDTH-1:0] MIN_V =
        {{(RESULT_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
      always_comb begin
        conv     = sel[DATA_WIDTH-1:0];
        conv_sat = 1'b0;
        if ($signed(sel) > $signed(MAX_V)) begin
          conv     = MAX_V[DATA_WIDTH-1:0];
          conv_sat = 1'b1;
        end else if ($signed(sel) < $signed(MIN_V)) begin
          conv     = MIN_V[DATA_WIDTH-1:0];
          conv_sat = 1'b1;
        end
      end
    end else begin : g_ext
      assign conv     = DATA_WIDTH'($signed(sel));
      assign conv_sat = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_q   <= '0;
      ch_q     <= '0;
      ptr_q    <= '0;
      rem_q    <= '0;
      full_q   <= 1'b0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch_q    <= ch_nxt;
      ptr_q   <= ptr_nxt;
      rem_q   <= rem_nxt;
      full_q  <= full_nxt;
      if (load_beat) beat_q <= bus.res_data;
      ready_q <= (state_nxt == CAPTURE);
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
      we_q    <= issue && !drop;
      if (issue) begin
        addr_q <= ptr_q;
        data_q <= conv;
      end
      if (clear_flags)          sat_flag <= 1'b0;
      else if (issue && conv_sat) sat_flag <= 1'b1;
      if (clear_flags)          overflow <= 1'b0;
      else if (issue && drop)   overflow <= 1'b1;
    end
  end

  assign bus.res_ready     = ready_q;
  assign bus.write_en      = we_q;
  assign bus.write_address = addr_q;
  assign bus.data_in       = data_q;

endmodule
